spi_master_seq: RTL

// - Host-side SPI master that sequences single-byte transactions to the 32x8 SPI register RAM slave.
// - Accepts read / read-increment / write commands on a valid-ready port and serialises one frame per command.
// - Returns read data or a write completion on a response pulse. Sits between the local command source and the SCLK/CS/MOSI/MISO pins.

---
 rtl/spi_master_seq_if.sv | 23 ++
 rtl/spi_master_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/spi_master_seq_if.sv
// Command/response port of the SPI register-RAM master.
// The master modport is the command source; the slave modport is the sequencer.
interface spi_master_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_mode, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/spi_master_seq.sv
// SPI master sequencing one 17-bit frame (mode, addr, turnaround, data) per command
// to the 32x8 register RAM slave; returns read data or write completion on a pulse.
module spi_master_seq #(
  parameter int HALF_DIV = 2,
  parameter int CS_GAP   = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_seq_if.slave cmd,
  output logic            SCLK,
  output logic            CS,
  output logic            MOSI,
  input  logic            MISO
);
  localparam int HW      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int GAP_CYC = CS_GAP * 2 * HALF_DIV;
  localparam int GW      = $clog2(GAP_CYC);
  localparam logic [HW-1:0] H_LAST = HW'(HALF_DIV - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, INF, DATA, GAP, ERR} state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [4:0]    bitcnt;
  logic [GW-1:0] gcnt;
  logic [16:0]   frame;
  logic [16:0]   frame_in;
  logic [7:0]    shreg, shreg_nxt;
  logic          is_wr;
  logic [4:0]    nbit;
  logic [2:0]    didx;

  // Frame bit order on the wire is frame[0] first: mode, addr LSB-first, 2 idle, data LSB-first.
  assign frame_in = {(cmd.cmd_mode == 2'b10) ? cmd.cmd_wdata : 8'h00, 2'b00,
                     cmd.cmd_addr, cmd.cmd_mode};
  assign nbit = bitcnt + 5'd1;

  // Data bits occupy frame periods 9..16; MISO is captured in the first high-half cycle.
  always_comb begin
    shreg_nxt = shreg;
    didx      = bitcnt[2:0] - 3'd1;
    if (state == DATA && SCLK && hcnt == '0 && bitcnt >= 5'd9)
      shreg_nxt[didx] = MISO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      SCLK          <= 1'b0;
      CS            <= 1'b1;
      MOSI          <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_err   <= 1'b0;
      cmd.rsp_rdata <= 8'h00;
      cmd.busy      <= 1'b0;
      hcnt          <= '0;
      bitcnt        <= '0;
      gcnt          <= '0;
      frame         <= '0;
      shreg         <= '0;
      is_wr         <= 1'b0;
    end else begin
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_err   <= 1'b0;
      case (state)
        IDLE: if (cmd.cmd_valid) begin
          cmd.cmd_ready <= 1'b0;
          cmd.busy      <= 1'b1;
          if (cmd.cmd_mode == 2'b11) begin
            state <= ERR;
          end else begin
            state  <= INF;
            CS     <= 1'b0;
            SCLK   <= 1'b0;
            MOSI   <= frame_in[0];
            frame  <= frame_in;
            is_wr  <= cmd.cmd_mode == 2'b10;
            hcnt   <= '0;
            bitcnt <= '0;
          end
        end
        ERR: begin
          cmd.rsp_valid <= 1'b1;
          cmd.rsp_err   <= 1'b1;
          cmd.cmd_ready <= 1'b1;
          cmd.busy      <= 1'b0;
          state         <= IDLE;
        end
        INF, DATA: begin
          shreg <= shreg_nxt;
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else begin
              SCLK <= 1'b0;
              if (bitcnt == 5'd16) begin
                state         <= GAP;
                CS            <= 1'b1;
                MOSI          <= 1'b0;
                bitcnt        <= '0;
                gcnt          <= '0;
                cmd.rsp_valid <= 1'b1;
                if (!is_wr) cmd.rsp_rdata <= shreg_nxt;
              end else begin
                bitcnt <= nbit;
                MOSI   <= frame[nbit];
                if (bitcnt == 5'd6) state <= DATA;
              end
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == G_LAST) begin
            gcnt          <= '0;
            state         <= IDLE;
            cmd.cmd_ready <= 1'b1;
            cmd.busy      <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
